// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM state encoding and
// serial-line bit levels. The 3-bit state width matches the downstream
// alternating-sequence detector so both can be probed the same way.
package serial_bit_feeder_pkg;

    // FSM state encoding. PAR is only entered when SERIAL_FEEDER_PARITY_EN
    // is defined, but the code point stays reserved in every build.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        PAR   = 3'd2
    } state_e;

    // Serial-line levels: a qualifier/bit that is active, or the idle level.
    localparam logic BIT_VALID = 1'b1;
    localparam logic BIT_IDLE  = 1'b0;

    // Even parity update: fold one more serial bit into the running XOR.
    function automatic logic parity_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial converter feeding the alternating
// sequence detector one bit per clock on x.
//
// Parallel side handshake: a word moves from producer to this block at a
// posedge where din_valid=1 and din_ready=1. din_ready depends only on the
// internal state, never on din_valid, and the producer holds din stable
// until the transfer edge. din_ready is high in IDLE and in the final
// output cycle of a word, so a waiting word is reloaded with no bubble.
//
// Serial side: x_valid qualifies x, x is forced low when x_valid=0, last
// marks the final bit of a frame, busy is high while a word is in flight.
//
// Build option: define SERIAL_FEEDER_PARITY_EN to append one even-parity
// bit (XOR of the data bits) after each word; last then marks the parity
// bit instead of the final data bit. Without the macro there is no PAR
// state and no parity flop.
//
// dbg_state exposes the FSM state for probes and checkers.
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         x,
    output logic         x_valid,
    output logic         last,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    state_e         state_q, state_d;
    logic [W-1:0]   sreg_q,  sreg_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic           par_q,   par_d;
`endif

    logic           cur_bit;
    logic [W-1:0]   sreg_shifted;
    logic           final_cycle;
    logic           take;

    // Bit currently at the output end of the shift register and the
    // register contents after one shift toward that end.
    always_comb begin
        cur_bit      = BIT_IDLE;
        sreg_shifted = '0;
        if (MSB_FIRST) begin
            cur_bit      = sreg_q[W-1];
            sreg_shifted = {sreg_q[W-2:0], 1'b0};
        end else begin
            cur_bit      = sreg_q[0];
            sreg_shifted = {1'b0, sreg_q[W-1:1]};
        end
    end

    // The last output cycle of a frame is where a new word may be reloaded.
    always_comb begin
`ifdef SERIAL_FEEDER_PARITY_EN
        final_cycle = (state_q == PAR);
`else
        final_cycle = (state_q == SHIFT) && (cnt_q == CNT_ZERO);
`endif
        din_ready = (state_q == IDLE) || final_cycle;
        take      = din_valid && din_ready;
    end

    // Next-state logic: load on transfer, shift while data bits remain,
    // then parity (if built in), then reload back-to-back or go idle.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_FEEDER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SHIFT;
                    sreg_d  = din;
                    cnt_d   = CNT_LOAD;
`ifdef SERIAL_FEEDER_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
`ifdef SERIAL_FEEDER_PARITY_EN
                par_d = parity_step(par_q, cur_bit);
`endif
                if (cnt_q != CNT_ZERO) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
                    state_d = PAR;
                    sreg_d  = '0;
`else
                    if (take) begin
                        sreg_d = din;
                        cnt_d  = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                        sreg_d  = '0;
                    end
`endif
                end
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            PAR: begin
                if (take) begin
                    state_d = SHIFT;
                    sreg_d  = din;
                    cnt_d   = CNT_LOAD;
                    par_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    par_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers; reset abandons any word in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= CNT_ZERO;
`ifdef SERIAL_FEEDER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_FEEDER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serial outputs decoded purely from registered state.
    always_comb begin
        x       = BIT_IDLE;
        x_valid = BIT_IDLE;
        last    = BIT_IDLE;
        busy    = BIT_IDLE;
        case (state_q)
            SHIFT: begin
                x       = cur_bit;
                x_valid = BIT_VALID;
                busy    = BIT_VALID;
`ifndef SERIAL_FEEDER_PARITY_EN
                last    = (cnt_q == CNT_ZERO);
`endif
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            PAR: begin
                x       = par_q;
                x_valid = BIT_VALID;
                busy    = BIT_VALID;
                last    = BIT_VALID;
            end
`endif
            default: begin
                x       = BIT_IDLE;
                x_valid = BIT_IDLE;
                last    = BIT_IDLE;
                busy    = BIT_IDLE;
            end
        endcase
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first instance checked through
// an expected-bit queue, plus an LSB-first instance checked cycle by cycle.
// Works with or without SERIAL_FEEDER_PARITY_EN defined.
module tb_serial_bit_feeder;

  localparam int W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FRAME = W + PAR_EN;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // MSB-first DUT
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, x, x_valid, last, busy;
  logic [2:0]   dbg_state;

  // LSB-first DUT
  logic [W-1:0] din2 = '0;
  logic         din2_valid = 1'b0;
  logic         rdy2, x2, xv2, last2, busy2;
  logic [2:0]   st2;

  serial_bit_feeder #(.W(W), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .last(last),
    .busy(busy), .dbg_state(dbg_state)
  );

  serial_bit_feeder #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din2), .din_valid(din2_valid),
    .din_ready(rdy2), .x(x2), .x_valid(xv2), .last(last2),
    .busy(busy2), .dbg_state(st2)
  );

  // scoreboard
  int num_checks = 0;
  int num_fail = 0;
  logic [1:0] exp_q[$];  // {last, x} per expected valid bit

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fail++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected frame for the MSB-first instance
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      logic b;
      logic l;
      b = w[W-1-i];
      l = (PAR_EN == 0) && (i == W - 1);
      exp_q.push_back({l, b});
    end
    if (PAR_EN != 0) exp_q.push_back({1'b1, ^w});
  endtask

  // monitor: every valid bit must match the queue head; idle must be quiet
  always @(negedge clk) begin
    if (x_valid && !reset) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_bit", {last, x}, 2'b11 ^ {last, x});
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check_eq("serial_bit", {30'd0, last, x}, {30'd0, e});
      end
    end else if (!x_valid) begin
      check_eq("idle_quiet", {29'd0, x, last, busy}, 32'd0);
    end
  end

  // drivers
  task automatic expect_idle(input string tag);
    check_eq({tag, "_state"}, dbg_state, 3'd0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_ready"}, din_ready, 1'b1);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic send_single(input logic [W-1:0] w, input string tag);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    push_word(w);
    @(negedge clk);              // cycle 1 after acceptance
    din_valid = 1'b0;
    check_eq({tag, "_c1_valid"}, x_valid, 1'b1);
    check_eq({tag, "_c1_ready"}, din_ready, 1'b0);
    repeat (FRAME - 1) @(negedge clk);
    check_eq({tag, "_cl_last"}, last, 1'b1);
    check_eq({tag, "_cl_ready"}, din_ready, 1'b1);
    @(negedge clk);
    expect_idle(tag);
  endtask

  // a held before acceptance, b presented from cycle 1 with din_valid held
  task automatic send_b2b(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    din = a;
    din_valid = 1'b1;
    push_word(a);
    push_word(b);
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (i == 1) din = b;
      if (i == FRAME + 1) din_valid = 1'b0;
      check_eq($sformatf("%s_valid_c%0d", tag, i), x_valid, 1'b1);
      check_eq($sformatf("%s_ready_c%0d", tag, i), din_ready,
               (i == FRAME || i == 2 * FRAME) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    expect_idle(tag);
  endtask

  task automatic send_lsb(input logic [W-1:0] w, input string tag);
    @(negedge clk);
    din2 = w;
    din2_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      din2_valid = 1'b0;
      check_eq($sformatf("%s_x_c%0d", tag, i + 1), x2, (i < W) ? w[i] : ^w);
      check_eq($sformatf("%s_valid_c%0d", tag, i + 1), xv2, 1'b1);
      check_eq($sformatf("%s_last_c%0d", tag, i + 1), last2, (i == FRAME - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check_eq({tag, "_idle_valid"}, xv2, 1'b0);
    check_eq({tag, "_idle_busy"}, busy2, 1'b0);
    check_eq({tag, "_idle_ready"}, rdy2, 1'b1);
    check_eq({tag, "_idle_state"}, st2, 3'd0);
  endtask

  initial begin
    // reset held with a word offered: nothing may start
    din = 8'hAA;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_x_valid", x_valid, 1'b0);
      check_eq("rst_x", x, 1'b0);
      check_eq("rst_last", last, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_ready", din_ready, 1'b1);
      check_eq("rst_state", dbg_state, 3'd0);
    end
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_idle("post_rst");

    // single word
    send_single(8'hAA, "single_aa");

    // back-to-back streams
    send_b2b(8'hAA, 8'h55, "b2b_aa_55");
    send_b2b(8'hAA, 8'hFF, "hold_ff");
    send_b2b(8'hA5, 8'h07, "b2b_a5_07");

    // reset during bit 4 of 8'hAA
    @(negedge clk);
    din = 8'hAA;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);   // bit 4 on the line
    check_eq("midrst_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_x_valid", x_valid, 1'b0);
    check_eq("midrst_x", x, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_ready", din_ready, 1'b1);
    check_eq("midrst_state", dbg_state, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_drained", exp_q.size(), 0);
    send_single(8'h55, "after_rst");

    // LSB-first instance
    send_lsb(8'h01, "lsb_01");
    send_lsb(8'h80, "lsb_80");
    send_lsb(8'h96, "lsb_96");

    repeat (2) @(negedge clk);
    check_eq("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
